audio_frame_buffer: RTL and testbench

- Consumes the per-sample stereo output of the audio codec driver (advance strobe plus 24-bit left/right ADC words).
- Mixes each stereo pair to mono and collects the mono samples into fixed-length frames in a two-bank (ping-pong) buffer.
- Streams each complete frame to the downstream spectral stage (FFT) over a valid/ready interface.
- Sits between the codec driver and the FFT front end.

---
 rtl/audio_frame_buffer.sv | 157 +++++++++++++++
 tb/tb_audio_frame_buffer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_frame_buffer.sv
// Stereo-to-mono frame collector: packs codec samples into ping-pong frames
// and streams each completed frame downstream over valid/ready.
module audio_frame_buffer #(
    parameter int FRAME_LEN = 256,
    parameter int IDX_W     = $clog2(FRAME_LEN),
    parameter int SAMPLE_W  = 24
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       advance,
    input  logic signed [SAMPLE_W-1:0] adc_left,
    input  logic signed [SAMPLE_W-1:0] adc_right,
    output logic signed [SAMPLE_W-1:0] out_data,
    output logic        [IDX_W-1:0]    out_index,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overflow,
    input  logic                       clear_overflow,
    output logic        [15:0]         drop_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM
    } rd_state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    rd_state_t                state, state_nxt;
    logic                     advance_q;
    logic                     strobe;
    logic signed [SAMPLE_W:0] mix_sum;
    logic        [SAMPLE_W-1:0] mono;
    logic        [1:0]        bank_full;
    logic                     wr_bank;
    logic                     rd_bank;
    logic        [IDX_W-1:0]  wr_ptr;
    logic                     wr_en;
    logic                     drop;
    logic                     wr_last;
    logic                     handshake;
    logic                     final_hs;
    logic        [IDX_W-1:0]  nxt_idx;
    logic        [IDX_W:0]    rd_addr;
    logic        [SAMPLE_W-1:0] mem [2*FRAME_LEN];

    // Rising edge of the codec's sample-ready level is the only sample event.
    assign strobe = advance & ~advance_q;

    // Sign-extended sum, arithmetic halve; truncation rounds toward -inf.
    assign mix_sum = {adc_left[SAMPLE_W-1], adc_left} + {adc_right[SAMPLE_W-1], adc_right};
    assign mono    = SAMPLE_W'(mix_sum >>> 1);

    assign wr_en   = strobe & ~bank_full[wr_bank];
    assign drop    = strobe &  bank_full[wr_bank];
    assign wr_last = (wr_ptr == LAST_IDX);

    assign handshake = out_valid & out_ready;
    assign final_hs  = handshake & out_last;
    assign nxt_idx   = out_index + IDX_W'(1);
    assign rd_addr   = (state == LOAD) ? {rd_bank, {IDX_W{1'b0}}} : {rd_bank, nxt_idx};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) advance_q <= 1'b0;
        else       advance_q <= advance;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[{wr_bank, wr_ptr}] <= mono;
    end

    // Writer and bank ownership. Writer only fills empty banks and the reader
    // only drains full ones, so set and clear never target the same bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            bank_full <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + IDX_W'(1);
                if (wr_last) begin
                    bank_full[wr_bank] <= 1'b1;
                    wr_bank            <= ~wr_bank;
                end
            end
            if (final_hs) begin
                bank_full[rd_bank] <= 1'b0;
                rd_bank            <= ~rd_bank;
            end
        end
    end

    // A drop in the same cycle as a clear leaves a count of exactly one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow   <= 1'b1;
            if (clear_overflow)            drop_count <= 16'd1;
            else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bank_full[rd_bank]) state_nxt = LOAD;
            LOAD:    state_nxt = STREAM;
            STREAM:  if (final_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output word register: loaded from the bank on LOAD and on each
    // non-final handshake, otherwise held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    out_valid <= 1'b1;
                    out_data  <= mem[rd_addr];
                    out_index <= '0;
                    out_last  <= 1'b0;
                end
                STREAM: begin
                    if (final_hs) begin
                        out_valid <= 1'b0;
                    end else if (handshake) begin
                        out_data  <= mem[rd_addr];
                        out_index <= nxt_idx;
                        out_last  <= (nxt_idx == LAST_IDX);
                    end
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Directed bench for audio_frame_buffer with FRAME_LEN=8.
module tb_audio_frame_buffer;

    localparam int FL = 8;
    localparam int IW = 3;
    localparam int SW = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          advance;
    logic [SW-1:0] adc_left;
    logic [SW-1:0] adc_right;
    logic [SW-1:0] out_data;
    logic [IW-1:0] out_index;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          overflow;
    logic          clear_overflow;
    logic [15:0]   drop_count;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [SW-1:0] cap_d [FL];
    logic [IW-1:0] cap_i [FL];
    logic          cap_l [FL];
    int            cap_n;

    audio_frame_buffer #(.FRAME_LEN(FL), .IDX_W(IW), .SAMPLE_W(SW)) dut (
        .clk            (clk),
        .reset          (reset),
        .advance        (advance),
        .adc_left       (adc_left),
        .adc_right      (adc_right),
        .out_data       (out_data),
        .out_index      (out_index),
        .out_last       (out_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    // All tasks start and end just after a negedge.
    task automatic send_sample(input logic [SW-1:0] l, input logic [SW-1:0] r);
        advance = 1'b1; adc_left = l; adc_right = r;
        @(negedge clk);
        advance = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1; advance = 1'b0; out_ready = 1'b0; clear_overflow = 1'b0;
        adc_left = '0; adc_right = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Collect one frame with out_ready held high; gives up after 200 cycles.
    task automatic capture_frame;
        cap_n = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 200 && cap_n < FL; c++) begin
            if (out_valid) begin
                cap_d[cap_n] = out_data; cap_i[cap_n] = out_index; cap_l[cap_n] = out_last;
                cap_n++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; advance = 1'b0; out_ready = 1'b1; clear_overflow = 1'b0;
        adc_left = '0; adc_right = '0;
        @(negedge clk);
        tests_run++;
        if ({out_valid, out_last, overflow, out_index, out_data, drop_count} !== '0) begin
            tests_failed++;
            $display("FAIL reset_values: valid=%0b data=%0h idx=%0d last=%0b ovf=%0b drops=%0d want all 0",
                     out_valid, out_data, out_index, out_last, overflow, drop_count);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mix;
        logic [SW-1:0] exp_mix [4];
        exp_mix[0] = 24'h7FFFFF; exp_mix[1] = 24'h800000; exp_mix[2] = 24'h000001; exp_mix[3] = 24'hFFFFFF;
        do_reset();
        send_sample(24'h7FFFFF, 24'h7FFFFF);
        send_sample(24'h800000, 24'h800000);
        send_sample(24'h000003, 24'h000000);
        send_sample(24'hFFFFFF, 24'h000000);
        for (int k = 5; k <= 8; k++) send_sample(24'(k), 24'(k));
        capture_frame();
        tests_run++;
        if (cap_n !== FL) begin tests_failed++; $display("FAIL mix_count: got %0d want %0d", cap_n, FL); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (cap_d[i] !== exp_mix[i] || cap_i[i] !== IW'(i)) begin
                tests_failed++;
                $display("FAIL mix_%0d: data=%0h idx=%0d want data=%0h idx=%0d", i, cap_d[i], cap_i[i], exp_mix[i], i);
            end
        end
    endtask

    task automatic test_basic_frame;
        do_reset();
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) send_sample(24'(k), 24'(k));
        // now one edge past the 8th write edge
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL latency_early: valid=%0b want 0 at E+1", out_valid); end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL latency_rise: valid=%0b want 1 at E+2", out_valid); end
        for (int i = 0; i < FL; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 24'(i + 1) || out_index !== IW'(i) || out_last !== (i == FL - 1)) begin
                tests_failed++;
                $display("FAIL basic_beat_%0d: valid=%0b data=%0h idx=%0d last=%0b want 1/%0h/%0d/%0b",
                         i, out_valid, out_data, out_index, out_last, i + 1, i, i == FL - 1);
            end
            @(negedge clk);
        end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_end: valid=%0b want 0", out_valid); end
    endtask

    task automatic test_backpressure;
        logic [3:0]    pat;
        logic          rdy_prev;
        logic          have_prev;
        logic [SW-1:0] pd;
        logic [IW-1:0] pi;
        int            n;
        pat = 4'b1001; rdy_prev = 1'b0; have_prev = 1'b0; pd = '0; pi = '0; n = 0;
        do_reset();
        for (int k = 0; k < FL; k++) send_sample(24'(16 + k), 24'(16 + k));
        for (int c = 0; c < 100 && n < FL; c++) begin
            out_ready = pat[c % 4];
            if (out_valid) begin
                if (have_prev && !rdy_prev) begin
                    tests_run++;
                    if (out_data !== pd || out_index !== pi) begin
                        tests_failed++;
                        $display("FAIL bp_hold: data=%0h idx=%0d want %0h/%0d", out_data, out_index, pd, pi);
                    end
                end
                if (out_ready) begin
                    tests_run++;
                    if (out_data !== 24'(16 + n) || out_index !== IW'(n)) begin
                        tests_failed++;
                        $display("FAIL bp_beat_%0d: data=%0h idx=%0d want %0h/%0d", n, out_data, out_index, 16 + n, n);
                    end
                    n++;
                end
                have_prev = 1'b1; pd = out_data; pi = out_index;
            end
            rdy_prev = out_ready;
            @(negedge clk);
        end
        tests_run++;
        if (n !== FL) begin tests_failed++; $display("FAIL bp_count: got %0d beats want %0d", n, FL); end
    endtask

    task automatic test_overflow;
        do_reset();
        for (int k = 1; k <= 17; k++) send_sample(24'(32'h100 + k), 24'(32'h100 + k));
        tests_run++;
        if (overflow !== 1'b1 || drop_count !== 16'd1) begin
            tests_failed++; $display("FAIL ovf_flag: ovf=%0b drops=%0d want 1/1", overflow, drop_count);
        end
        capture_frame();
        tests_run++;
        if (cap_n !== FL) begin tests_failed++; $display("FAIL ovf_f0_count: got %0d want %0d", cap_n, FL); end
        for (int i = 0; i < FL; i++) begin
            tests_run++;
            if (cap_d[i] !== 24'(32'h101 + i)) begin
                tests_failed++; $display("FAIL ovf_f0_%0d: got %0h want %0h", i, cap_d[i], 32'h101 + i);
            end
        end
        capture_frame();
        for (int i = 0; i < FL; i++) begin
            tests_run++;
            if (cap_d[i] !== 24'(32'h109 + i) || cap_i[i] !== IW'(i)) begin
                tests_failed++; $display("FAIL ovf_f1_%0d: got %0h/%0d want %0h/%0d", i, cap_d[i], cap_i[i], 32'h109 + i, i);
            end
        end
        for (int k = 0; k < FL; k++) send_sample(24'(32'h200 + k), 24'(32'h200 + k));
        capture_frame();
        tests_run++;
        if (cap_n !== FL || cap_d[0] !== 24'h200 || cap_i[0] !== '0 || cap_d[7] !== 24'h207 || cap_l[7] !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_next: n=%0d d0=%0h i0=%0d d7=%0h l7=%0b want 8/200/0/207/1", cap_n, cap_d[0], cap_i[0], cap_d[7], cap_l[7]);
        end
    endtask

    task automatic test_advance_hold;
        do_reset();
        advance = 1'b1; adc_left = 24'h55; adc_right = 24'h55;
        repeat (5) @(negedge clk);
        advance = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 7; k++) send_sample(24'(k), 24'(k));
        capture_frame();
        tests_run++;
        if (cap_n !== FL || cap_d[0] !== 24'h55 || cap_d[1] !== 24'h1 || cap_d[7] !== 24'h7) begin
            tests_failed++;
            $display("FAIL hold_single: n=%0d d0=%0h d1=%0h d7=%0h want 8/55/1/7", cap_n, cap_d[0], cap_d[1], cap_d[7]);
        end
    endtask

    task automatic test_coincident;
        logic done;
        done = 1'b0;
        do_reset();
        for (int k = 0; k < 2 * FL; k++) send_sample(24'(32'h300 + k), 24'(32'h300 + k));
        for (int c = 0; c < 40 && !done; c++) begin
            out_ready = 1'b1;
            if (out_valid && out_last) begin
                advance = 1'b1; adc_left = 24'h3FF; adc_right = 24'h3FF;
                done = 1'b1;
            end
            @(negedge clk);
        end
        advance = 1'b0;
        tests_run++;
        if (done !== 1'b1 || overflow !== 1'b1 || drop_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL coincide_drop: seen_last=%0b ovf=%0b drops=%0d want 1/1/1", done, overflow, drop_count);
        end
        capture_frame();
        tests_run++;
        if (cap_n !== FL || cap_d[0] !== 24'h308 || cap_d[7] !== 24'h30F) begin
            tests_failed++; $display("FAIL coincide_f1: n=%0d d0=%0h d7=%0h want 8/308/30f", cap_n, cap_d[0], cap_d[7]);
        end
        out_ready = 1'b0;
        for (int k = 0; k < FL; k++) send_sample(24'(32'h400 + k), 24'(32'h400 + k));
        capture_frame();
        tests_run++;
        if (cap_n !== FL || cap_d[0] !== 24'h400 || cap_i[0] !== '0 || cap_d[7] !== 24'h407) begin
            tests_failed++; $display("FAIL coincide_next: n=%0d d0=%0h i0=%0d d7=%0h want 8/400/0/407", cap_n, cap_d[0], cap_i[0], cap_d[7]);
        end
        // clear racing a drop: drop_count is 1 going in, so a plain increment would give 2
        out_ready = 1'b0;
        for (int k = 0; k < 2 * FL; k++) send_sample(24'(k), 24'(k));
        advance = 1'b1; clear_overflow = 1'b1; adc_left = 24'h7; adc_right = 24'h7;
        @(negedge clk);
        advance = 1'b0; clear_overflow = 1'b0;
        tests_run++;
        if (overflow !== 1'b1 || drop_count !== 16'd1) begin
            tests_failed++; $display("FAIL clear_race: ovf=%0b drops=%0d want 1/1", overflow, drop_count);
        end
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        tests_run++;
        if (overflow !== 1'b0 || drop_count !== 16'd0) begin
            tests_failed++; $display("FAIL clear_plain: ovf=%0b drops=%0d want 0/0", overflow, drop_count);
        end
    endtask

    task automatic test_mid_reset;
        logic hit;
        hit = 1'b0;
        do_reset();
        for (int k = 0; k < FL + 3; k++) send_sample(24'(32'h600 + k), 24'(32'h600 + k));
        out_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (out_valid && out_index == IW'(4)) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (hit !== 1'b1 || {out_valid, out_last, overflow, out_index, out_data, drop_count} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_vals: hit=%0b valid=%0b data=%0h idx=%0d last=%0b want hit=1 rest 0",
                     hit, out_valid, out_data, out_index, out_last);
        end
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        for (int k = 0; k < FL; k++) send_sample(24'(32'h500 + k), 24'(32'h500 + k));
        capture_frame();
        tests_run++;
        if (cap_n !== FL) begin tests_failed++; $display("FAIL midreset_count: got %0d want %0d", cap_n, FL); end
        for (int i = 0; i < FL; i++) begin
            tests_run++;
            if (cap_d[i] !== 24'(32'h500 + i) || cap_i[i] !== IW'(i) || cap_l[i] !== (i == FL - 1)) begin
                tests_failed++;
                $display("FAIL midreset_%0d: got %0h/%0d/%0b want %0h/%0d/%0b", i, cap_d[i], cap_i[i], cap_l[i], 32'h500 + i, i, i == FL - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mix();
        test_basic_frame();
        test_backpressure();
        test_overflow();
        test_advance_hold();
        test_coincident();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
